// File: rtl/gl_mem_arbiter.sv
// gl_mem_arbiter: shares one BRAM read port between gl_fetch (single words)
// and gl_decode (1-4 word bursts). Grants are round-robin in IDLE. Decode
// bursts are sequenced in BURST. Read returns are steered by a one-cycle tag
// pipeline. The last decode word is bypassed into dec_data so that dec_done
// arrives len+1 cycles after dec_gnt.
module gl_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [ADDR_W-1:0]     fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_valid,
  output logic [DATA_W-1:0]     fetch_data,
  input  logic                  dec_req,
  input  logic [ADDR_W-1:0]     dec_addr,
  input  logic [1:0]            dec_len,
  output logic                  dec_gnt,
  output logic                  dec_done,
  output logic [4*DATA_W-1:0]   dec_data,
  output logic                  mem_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall
);

  typedef enum logic { S_IDLE, S_BURST } state_t;
  typedef enum logic { OWN_FETCH, OWN_DEC } owner_t;

  state_t              r_state;
  owner_t              r_last_owner;
  logic [ADDR_W-1:0]   r_base;
  logic [1:0]          r_len;
  logic [1:0]          r_idx;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_tag_valid;
  owner_t              r_tag_owner;
  logic [1:0]          r_tag_idx;
  logic                r_tag_last;
  logic [DATA_W-1:0]   r_fetch_data;
  logic [4*DATA_W-1:0] r_dec_data;

  logic                w_fetch_gnt;
  logic                w_dec_gnt;
  logic                w_mem_en;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic [1:0]          w_issue_idx;
  logic                w_issue_last;
  logic                w_fetch_ret;
  logic                w_dec_ret;
  logic [4*DATA_W-1:0] w_dec_data;

  // Grant decision and BRAM issue: round-robin in IDLE, sequential burst words in BURST.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    w_fetch_gnt  = 1'b0;
    w_dec_gnt    = 1'b0;
    w_mem_en     = 1'b0;
    w_issue_addr = r_mem_addr;
    w_issue_idx  = 2'd0;
    w_issue_last = 1'b0;
    if (!reset) begin
      if (r_state == S_BURST) begin
        w_mem_en     = 1'b1;
        w_issue_addr = r_base + ADDR_W'(r_idx);
        w_issue_idx  = r_idx;
        w_issue_last = (r_idx == r_len);
      end else if (fetch_req && (!dec_req || r_last_owner == OWN_DEC)) begin
        w_fetch_gnt  = 1'b1;
        w_mem_en     = 1'b1;
        w_issue_addr = fetch_addr;
      end else if (dec_req) begin
        w_dec_gnt    = 1'b1;
        w_mem_en     = 1'b1;
        w_issue_addr = dec_addr;
        w_issue_last = (dec_len == 2'd0);
      end
    end
  end

  // Read return steering; the word returning this cycle is merged into dec_data directly.
  always_comb begin
    w_fetch_ret = r_tag_valid && (r_tag_owner == OWN_FETCH);
    w_dec_ret   = r_tag_valid && (r_tag_owner == OWN_DEC);
    w_dec_data  = r_dec_data;
    if (w_dec_ret) begin
      w_dec_data[DATA_W*int'(r_tag_idx) +: DATA_W] = mem_rdata;
    end
  end

  assign fetch_gnt   = w_fetch_gnt;
  assign dec_gnt     = w_dec_gnt;
  assign mem_en      = w_mem_en;
  assign mem_addr    = w_issue_addr;
  assign fetch_valid = w_fetch_ret;
  assign fetch_data  = w_fetch_ret ? mem_rdata : r_fetch_data;
  assign dec_done    = w_dec_ret && r_tag_last;
  assign dec_data    = w_dec_data;
  assign stall       = !reset && (dec_req || (r_state == S_BURST) || (fetch_req && !w_fetch_gnt));

  // Arbiter state, burst counters, tag pipeline and held return data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_owner <= OWN_FETCH;
      r_base       <= '0;
      r_len        <= '0;
      r_idx        <= '0;
      r_mem_addr   <= '0;
      r_tag_valid  <= 1'b0;
      r_tag_owner  <= OWN_FETCH;
      r_tag_idx    <= '0;
      r_tag_last   <= 1'b0;
      r_fetch_data <= '0;
      r_dec_data   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_tag_valid <= w_mem_en;
      r_tag_owner <= w_fetch_gnt ? OWN_FETCH : OWN_DEC;
      r_tag_idx   <= w_issue_idx;
      r_tag_last  <= w_issue_last;
      if (w_mem_en) begin
        r_mem_addr <= w_issue_addr;
      end
      if (w_fetch_gnt) begin
        r_last_owner <= OWN_FETCH;
      end else if (w_dec_gnt) begin
        r_last_owner <= OWN_DEC;
      end
      if (w_fetch_ret) begin
        r_fetch_data <= mem_rdata;
      end
      // A new burst starts from a clean result; the bypassed final word of the
      // previous burst is still visible on dec_data during the grant cycle.
      if (w_dec_gnt) begin
        r_dec_data <= '0;
      end else begin
        r_dec_data <= w_dec_data;
      end
      if (r_state == S_IDLE) begin
        if (w_dec_gnt) begin
          r_base <= dec_addr;
          r_len  <= dec_len;
          r_idx  <= 2'd1;
          if (dec_len != 2'd0) begin
            r_state <= S_BURST;
          end
        end
      end else begin
        r_idx <= r_idx + 2'd1;
        if (r_idx == r_len) begin
          r_state <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_gl_mem_arbiter.sv
// Testbench for gl_mem_arbiter: a vector table for IDLE arbitration, hand
// sequences for bursts, wrap, reset abort and alternation, and a scoreboard
// that predicts every returned fetch word and decode burst from the grants.
module tb_gl_mem_arbiter;

  localparam int          ADDR_W = 32;
  localparam int          DATA_W = 32;
  localparam logic [31:0] KEY    = 32'hA5A50000;

  logic                  clk;
  logic                  reset;
  logic                  fetch_req;
  logic [ADDR_W-1:0]     fetch_addr;
  logic                  fetch_gnt;
  logic                  fetch_valid;
  logic [DATA_W-1:0]     fetch_data;
  logic                  dec_req;
  logic [ADDR_W-1:0]     dec_addr;
  logic [1:0]            dec_len;
  logic                  dec_gnt;
  logic                  dec_done;
  logic [4*DATA_W-1:0]   dec_data;
  logic                  mem_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_rdata;
  logic                  stall;

  int n_checks = 0;
  int n_errors = 0;
  int dec_done_seen = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  len;
  } dec_exp_t;

  logic [31:0] fetch_q[$];
  dec_exp_t    dec_q[$];

  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [1:0]  d_len;
    logic        e_fgnt;
    logic        e_dgnt;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_stall;
  } vec_t;

  vec_t vecs[9];

  gl_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .dec_req     (dec_req),
    .dec_addr    (dec_addr),
    .dec_len     (dec_len),
    .dec_gnt     (dec_gnt),
    .dec_done    (dec_done),
    .dec_data    (dec_data),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .stall       (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: registered read, data = addr ^ KEY one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= mem_addr ^ KEY;
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] burst_exp(input logic [31:0] addr, input logic [1:0] len);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (k <= int'(len)) r[32*k +: 32] = (addr + 32'(k)) ^ KEY;
    end
    return r;
  endfunction

  // Scoreboard: predictions pushed on grants, compared on returns.
  always @(negedge clk) begin
    if (dec_done) dec_done_seen++;
    if (reset) begin
      fetch_q.delete();
      dec_q.delete();
    end else begin
      if (fetch_valid) begin
        if (fetch_q.size() == 0) check("fetch_unexpected", fetch_valid, 1'b0);
        else check("sb_fetch_data", fetch_data, fetch_q.pop_front());
      end
      if (dec_done) begin
        if (dec_q.size() == 0) check("dec_unexpected", dec_done, 1'b0);
        else begin
          dec_exp_t e;
          e = dec_q.pop_front();
          check("sb_dec_data", dec_data, burst_exp(e.addr, e.len));
        end
      end
      if (fetch_gnt) fetch_q.push_back(fetch_addr ^ KEY);
      if (dec_gnt) dec_q.push_back('{addr: dec_addr, len: dec_len});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    dec_req    = 1'b0;
    dec_addr   = '0;
    dec_len    = 2'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] fa;
    int          done_before;
    logic        prev_dgnt;
    logic        prev_fgnt;

    // Rows run back to back; round-robin state carries from row to row.
    vecs[0] = '{1'b0, 32'h0,   1'b0, 32'h0,   2'd0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[1] = '{1'b1, 32'h10,  1'b0, 32'h0,   2'd0, 1'b1, 1'b0, 1'b1, 32'h10,  1'b0};
    vecs[2] = '{1'b1, 32'h11,  1'b0, 32'h0,   2'd0, 1'b1, 1'b0, 1'b1, 32'h11,  1'b0};
    vecs[3] = '{1'b1, 32'h12,  1'b0, 32'h0,   2'd0, 1'b1, 1'b0, 1'b1, 32'h12,  1'b0};
    vecs[4] = '{1'b0, 32'h0,   1'b0, 32'h0,   2'd0, 1'b0, 1'b0, 1'b0, 32'h12,  1'b0};
    vecs[5] = '{1'b1, 32'h20,  1'b1, 32'h200, 2'd0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1};
    vecs[6] = '{1'b1, 32'h20,  1'b1, 32'h300, 2'd0, 1'b1, 1'b0, 1'b1, 32'h20,  1'b1};
    vecs[7] = '{1'b0, 32'h0,   1'b1, 32'h300, 2'd0, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1};
    vecs[8] = '{1'b0, 32'h0,   1'b0, 32'h0,   2'd0, 1'b0, 1'b0, 1'b0, 32'h300, 1'b0};

    // Reset state, with requests driven to show that grants are suppressed.
    idle_inputs();
    reset     = 1'b1;
    fetch_req = 1'b1;
    dec_req   = 1'b1;
    sample();
    check("reset_outputs",
          {fetch_gnt, fetch_valid, fetch_data, dec_gnt, dec_done, dec_data, mem_en, mem_addr, stall},
          256'h0);
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b0;

    // IDLE arbitration table: back-to-back fetches, round robin, address hold.
    for (int i = 0; i < 9; i++) begin
      step();
      fetch_req  = vecs[i].f_req;
      fetch_addr = vecs[i].f_addr;
      dec_req    = vecs[i].d_req;
      dec_addr   = vecs[i].d_addr;
      dec_len    = vecs[i].d_len;
      sample();
      check($sformatf("vec%0d_fetch_gnt", i), fetch_gnt, vecs[i].e_fgnt);
      check($sformatf("vec%0d_dec_gnt", i), dec_gnt, vecs[i].e_dgnt);
      check($sformatf("vec%0d_mem_en", i), mem_en, vecs[i].e_en);
      check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_stall", i), stall, vecs[i].e_stall);
    end
    check("fetch_data_hold", fetch_data, 32'hA5A50020);
    step();
    sample();
    check("dec_data_hold", dec_data, {96'h0, 32'hA5A50300});

    // Four-word decode burst.
    step();
    dec_req = 1'b1; dec_addr = 32'h100; dec_len = 2'd3;
    sample();
    check("b4_dec_gnt", dec_gnt, 1'b1);
    check("b4_addr0", mem_addr, 32'h100);
    check("b4_stall0", stall, 1'b1);
    step();
    dec_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (k > 1) step();
      sample();
      check($sformatf("b4_addr%0d", k), mem_addr, 32'h100 + 32'(k));
      check($sformatf("b4_en%0d", k), mem_en, 1'b1);
      check($sformatf("b4_stall%0d", k), stall, 1'b1);
      check($sformatf("b4_nodone%0d", k), dec_done, 1'b0);
    end
    step();
    sample();
    check("b4_done", dec_done, 1'b1);
    check("b4_data", dec_data, {32'hA5A50103, 32'hA5A50102, 32'hA5A50101, 32'hA5A50100});
    check("b4_stall_after", stall, 1'b0);

    // Simultaneous requests after reset: decode wins because last_owner is FETCH.
    do_reset();
    step();
    fetch_req = 1'b1; fetch_addr = 32'h20;
    dec_req = 1'b1; dec_addr = 32'h200; dec_len = 2'd1;
    sample();
    check("both_dec_gnt", dec_gnt, 1'b1);
    check("both_no_fetch_gnt", fetch_gnt, 1'b0);
    step();
    dec_req = 1'b0;
    sample();
    check("both_fetch_wait", fetch_gnt, 1'b0);
    check("both_stall_burst", stall, 1'b1);
    step();
    sample();
    check("both_fetch_gnt", fetch_gnt, 1'b1);
    check("both_fetch_addr", mem_addr, 32'h20);
    check("both_dec_done", dec_done, 1'b1);
    step();
    fetch_req = 1'b0;
    sample();
    check("both_fetch_valid", fetch_valid, 1'b1);
    check("both_fetch_data", fetch_data, 32'hA5A50020);

    // Address wrap, then a single-word burst granted as the wrap burst completes.
    step();
    dec_req = 1'b1; dec_addr = 32'hFFFF_FFFE; dec_len = 2'd3;
    sample();
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFE);
    step();
    dec_req = 1'b0;
    sample();
    check("wrap_addr1", mem_addr, 32'hFFFF_FFFF);
    step();
    sample();
    check("wrap_addr2", mem_addr, 32'h0000_0000);
    step();
    sample();
    check("wrap_addr3", mem_addr, 32'h0000_0001);
    step();
    dec_req = 1'b1; dec_addr = 32'h40; dec_len = 2'd0;
    sample();
    check("len0_gnt", dec_gnt, 1'b1);
    check("wrap_done", dec_done, 1'b1);
    step();
    dec_req = 1'b0;
    sample();
    check("len0_done", dec_done, 1'b1);
    check("len0_data", dec_data, {96'h0, 32'hA5A50040});

    // Reset asserted in the third cycle of a four-word burst.
    step();
    dec_req = 1'b1; dec_addr = 32'h500; dec_len = 2'd3;
    step();
    dec_req = 1'b0;
    step();
    fetch_req = 1'b1; fetch_addr = 32'h30;
    done_before = dec_done_seen;
    #2 reset = 1'b1;
    #1;
    check("abort_outputs",
          {fetch_gnt, fetch_valid, fetch_data, dec_gnt, dec_done, dec_data, mem_en, mem_addr, stall},
          256'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    sample();
    check("abort_no_done", dec_done_seen, done_before);
    check("abort_fetch_gnt", fetch_gnt, 1'b1);
    check("abort_fetch_addr", mem_addr, 32'h30);
    step();
    fetch_req = 1'b0;
    sample();
    check("abort_fetch_valid", fetch_valid, 1'b1);
    check("abort_fetch_data", fetch_data, 32'hA5A50030);

    // Continuous fetch with a single-word decode every other cycle: strict alternation.
    do_reset();
    step();
    fa = 32'h60;
    prev_dgnt = 1'b0;
    prev_fgnt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (prev_dgnt) dec_req = 1'b0;
      if (prev_fgnt) fa = fa + 32'd1;
      fetch_req  = 1'b1;
      fetch_addr = fa;
      if ((i % 2) == 0 && !dec_req) begin
        dec_req  = 1'b1;
        dec_addr = 32'h400 + 32'(i);
        dec_len  = 2'd0;
      end
      sample();
      check($sformatf("alt%0d_gnt", i), {fetch_gnt, dec_gnt}, ((i % 2) == 0) ? 2'b01 : 2'b10);
      check($sformatf("alt%0d_mem_en", i), mem_en, 1'b1);
      prev_dgnt = dec_gnt;
      prev_fgnt = fetch_gnt;
    end
    step();
    idle_inputs();
    repeat (3) step();
    sample();
    check("drain_fetch_q", fetch_q.size(), 0);
    check("drain_dec_q", dec_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
